ipml_hsst_rxlane_rst_fsm: RTL and testbench

//  Per-lane HSST RX reset sequencer. Orders PMA reset release, CDR lock qualification,
//  PCS reset release, word-align wait and the RX FIFO clear pulse, then flags lane done.
//  Its o_fifo_clr / o_rxlane_done feed the lane fifo-clear controller; one instance per lane.

---
 rtl/ipml_hsst_rxlane_rst_fsm_if.sv | 24 ++
 rtl/ipml_hsst_rxlane_rst_fsm.sv | 152 +++++++++++++++
 tb/tb_ipml_hsst_rxlane_rst_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ipml_hsst_rxlane_rst_fsm_if.sv
// Lane-side handshake bundle of the HSST RX lane reset sequencer.
interface ipml_hsst_rxlane_rst_fsm_if;
  logic       i_pll_lock;
  logic       i_los;
  logic       i_cdr_align;
  logic       i_word_align;
  logic       o_pma_rx_rst;
  logic       o_pcs_rx_rst;
  logic       o_fifo_clr;
  logic       o_rxlane_done;
  logic [3:0] o_retry_cnt;

  // Driver side: supplies lane status, observes resets and status.
  modport master (
    output i_pll_lock, i_los, i_cdr_align, i_word_align,
    input  o_pma_rx_rst, o_pcs_rx_rst, o_fifo_clr, o_rxlane_done, o_retry_cnt
  );

  // Sequencer side.
  modport slave (
    input  i_pll_lock, i_los, i_cdr_align, i_word_align,
    output o_pma_rx_rst, o_pcs_rx_rst, o_fifo_clr, o_rxlane_done, o_retry_cnt
  );
endinterface

// File: rtl/ipml_hsst_rxlane_rst_fsm.sv
// Per-lane HSST RX reset sequencer: PMA reset, CDR qualification, PCS reset,
// word-align wait, FIFO clear pulse, lane done; loss events re-enter the sequence.
module ipml_hsst_rxlane_rst_fsm #(
  parameter string       RX_ENABLE       = "TRUE",
  parameter int unsigned PMA_RST_CNT     = 256,
  parameter int unsigned CDR_LOCK_CNT    = 1024,
  parameter int unsigned PCS_RST_CNT     = 64,
  parameter int unsigned ALIGN_TIMEOUT   = 65535,
  parameter int unsigned FIFO_CLR_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ipml_hsst_rxlane_rst_fsm_if.slave     lane
);

  localparam int unsigned MAX_A  = (PMA_RST_CNT > CDR_LOCK_CNT) ? PMA_RST_CNT : CDR_LOCK_CNT;
  localparam int unsigned MAX_B  = (PCS_RST_CNT > ALIGN_TIMEOUT) ? PCS_RST_CNT : ALIGN_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MX = (MAX_C > FIFO_CLR_CYCLES) ? MAX_C : FIFO_CLR_CYCLES;
  localparam int unsigned CNT_W  = $clog2(CNT_MX + 1);
  localparam bit          EN     = (RX_ENABLE == "TRUE");

  typedef enum logic [2:0] {
    ST_PMA_RST    = 3'd0,
    ST_WAIT_CDR   = 3'd1,
    ST_PCS_RST    = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_FIFO_CLR   = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  generate
    if (EN) begin : g_fsm
      logic [3:0]       sync1_q, sync2_q;
      logic             pll_s, los_s, cdr_s, walign_s, qual;
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d, qcnt_q, qcnt_d;
      logic [3:0]       retry_q;
      logic             retry_inc;
      logic             pma_q, pcs_q, clr_q, done_q;
      logic             pma_d, pcs_d, clr_d, done_d;

      assign {pll_s, los_s, cdr_s, walign_s} = sync2_q;
      assign qual = cdr_s & ~los_s;

      // Two-flop synchronisers for the asynchronous lane status inputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 4'd0;
          sync2_q <= 4'd0;
        end else begin
          sync1_q <= {lane.i_pll_lock, lane.i_los, lane.i_cdr_align, lane.i_word_align};
          sync2_q <= sync1_q;
        end
      end

      // Next state: normal sequencing first, then loss events override in priority order.
      always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
          ST_PMA_RST:
            if (pll_s && (cnt_q == CNT_W'(PMA_RST_CNT - 1))) state_d = ST_WAIT_CDR;
          ST_WAIT_CDR:
            if (qual && (qcnt_q == CNT_W'(CDR_LOCK_CNT - 1))) begin
              state_d = ST_PCS_RST;
            end else if (cnt_q == CNT_W'(ALIGN_TIMEOUT - 1)) begin
              state_d   = ST_PMA_RST;
              retry_inc = 1'b1;
            end
          ST_PCS_RST:
            if (cnt_q == CNT_W'(PCS_RST_CNT - 1)) state_d = ST_WAIT_ALIGN;
          ST_WAIT_ALIGN:
            if (walign_s) begin
              state_d = ST_FIFO_CLR;
            end else if (cnt_q == CNT_W'(ALIGN_TIMEOUT - 1)) begin
              state_d   = ST_PCS_RST;
              retry_inc = 1'b1;
            end
          ST_FIFO_CLR:
            if (cnt_q == CNT_W'(FIFO_CLR_CYCLES - 1)) state_d = ST_DONE;
          ST_DONE: state_d = ST_DONE;
          default: state_d = ST_PMA_RST;
        endcase

        if ((state_q != ST_PMA_RST) && !pll_s) begin
          state_d   = ST_PMA_RST;
          retry_inc = 1'b0;
        end else if ((state_q inside {ST_PCS_RST, ST_WAIT_ALIGN, ST_FIFO_CLR, ST_DONE}) && !qual) begin
          state_d   = ST_WAIT_CDR;
          retry_inc = 1'b0;
        end else if ((state_q inside {ST_FIFO_CLR, ST_DONE}) && !walign_s) begin
          state_d   = ST_PCS_RST;
          retry_inc = 1'b0;
        end
      end

      // Counter updates and output decode of the state being entered.
      always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        qcnt_d = '0;
        if (state_d != state_q) begin
          cnt_d = '0;
        end else begin
          if ((state_q == ST_PMA_RST) && !pll_s) cnt_d = '0;
          if ((state_q == ST_WAIT_CDR) && qual) qcnt_d = qcnt_q + CNT_W'(1);
        end
        pma_d  = (state_d == ST_PMA_RST);
        pcs_d  = (state_d inside {ST_PMA_RST, ST_WAIT_CDR, ST_PCS_RST});
        clr_d  = (state_d == ST_FIFO_CLR);
        done_d = (state_d == ST_DONE);
      end

      // State, counters, saturating retry count and registered outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_PMA_RST;
          cnt_q   <= '0;
          qcnt_q  <= '0;
          retry_q <= 4'd0;
          pma_q   <= 1'b1;
          pcs_q   <= 1'b1;
          clr_q   <= 1'b0;
          done_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          qcnt_q  <= qcnt_d;
          if (retry_inc && (retry_q != 4'hF)) retry_q <= retry_q + 4'd1;
          pma_q   <= pma_d;
          pcs_q   <= pcs_d;
          clr_q   <= clr_d;
          done_q  <= done_d;
        end
      end

      assign lane.o_pma_rx_rst  = pma_q;
      assign lane.o_pcs_rx_rst  = pcs_q;
      assign lane.o_fifo_clr    = clr_q;
      assign lane.o_rxlane_done = done_q;
      assign lane.o_retry_cnt   = retry_q;
    end else begin : g_off
      // Lane disabled: hold resets asserted and status idle.
      assign lane.o_pma_rx_rst  = 1'b1;
      assign lane.o_pcs_rx_rst  = 1'b1;
      assign lane.o_fifo_clr    = 1'b0;
      assign lane.o_rxlane_done = 1'b0;
      assign lane.o_retry_cnt   = 4'd0;
    end
  endgenerate

endmodule

// File: tb/tb_ipml_hsst_rxlane_rst_fsm.sv
// Self-checking bench for the HSST RX lane reset sequencer.
module tb_ipml_hsst_rxlane_rst_fsm;

  localparam int PMA_N = 4;
  localparam int CDR_N = 8;
  localparam int PCS_N = 4;
  localparam int TO_N  = 20;
  localparam int FC_N  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_v;     // {pll_lock, los, cdr_align, word_align}
  logic       chk_on;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  ipml_hsst_rxlane_rst_fsm_if lane();
  ipml_hsst_rxlane_rst_fsm_if lane_off();

  assign {lane.i_pll_lock, lane.i_los, lane.i_cdr_align, lane.i_word_align} = in_v;
  assign {lane_off.i_pll_lock, lane_off.i_los, lane_off.i_cdr_align, lane_off.i_word_align} = in_v;

  ipml_hsst_rxlane_rst_fsm #(
    .RX_ENABLE("TRUE"), .PMA_RST_CNT(PMA_N), .CDR_LOCK_CNT(CDR_N),
    .PCS_RST_CNT(PCS_N), .ALIGN_TIMEOUT(TO_N), .FIFO_CLR_CYCLES(FC_N)
  ) dut (.clk(clk), .rst_n(rst_n), .lane(lane));

  ipml_hsst_rxlane_rst_fsm #(
    .RX_ENABLE("FALSE"), .PMA_RST_CNT(PMA_N), .CDR_LOCK_CNT(CDR_N),
    .PCS_RST_CNT(PCS_N), .ALIGN_TIMEOUT(TO_N), .FIFO_CLR_CYCLES(FC_N)
  ) dut_off (.clk(clk), .rst_n(rst_n), .lane(lane_off));

  function automatic logic [7:0] dut_out();
    return {lane.o_pma_rx_rst, lane.o_pcs_rx_rst, lane.o_fifo_clr, lane.o_rxlane_done,
            lane.o_retry_cnt};
  endfunction

  function automatic logic [7:0] off_out();
    return {lane_off.o_pma_rx_rst, lane_off.o_pcs_rx_rst, lane_off.o_fifo_clr,
            lane_off.o_rxlane_done, lane_off.o_retry_cnt};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {pma,pcs,clr,done,retry}=%h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Stages in sequence order; per-stage outputs {pma,pcs,clr,done}.
  localparam int S_PMA = 0, S_CDR = 1, S_PCS = 2, S_ALN = 3, S_CLR = 4, S_DONE = 5;
  logic [3:0] stage_out [6] = '{4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0001};

  int         m_stage = S_PMA;
  int         m_t     = 0;   // cycles spent in current stage
  int         m_q     = 0;   // consecutive qualified CDR cycles
  int         m_retry = 0;
  logic [3:0] m_seen [$] = '{4'd0, 4'd0};  // input history; front is what the sequencer sees

  function automatic logic [7:0] model_out();
    return {stage_out[m_stage], 4'(m_retry)};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_stage = S_PMA; m_t = 0; m_q = 0; m_retry = 0;
      m_seen = '{4'd0, 4'd0};
    end else begin
      logic s_pll, s_los, s_cdr, s_wa, qual, timeout;
      int   nxt;
      {s_pll, s_los, s_cdr, s_wa} = m_seen.pop_front();
      m_seen.push_back(in_v);
      qual    = s_cdr && !s_los;
      nxt     = m_stage;
      timeout = 1'b0;
      if (m_stage != S_PMA && !s_pll)            nxt = S_PMA;
      else if (m_stage >= S_PCS && !qual)        nxt = S_CDR;
      else if (m_stage >= S_CLR && !s_wa)        nxt = S_PCS;
      else begin
        case (m_stage)
          S_PMA: if (s_pll && m_t + 1 >= PMA_N) nxt = S_CDR;
          S_CDR: if (qual && m_q + 1 >= CDR_N) nxt = S_PCS;
                 else if (m_t + 1 >= TO_N) begin nxt = S_PMA; timeout = 1'b1; end
          S_PCS: if (m_t + 1 >= PCS_N) nxt = S_ALN;
          S_ALN: if (s_wa) nxt = S_CLR;
                 else if (m_t + 1 >= TO_N) begin nxt = S_PCS; timeout = 1'b1; end
          S_CLR: if (m_t + 1 >= FC_N) nxt = S_DONE;
          default: ;
        endcase
      end
      if (timeout && m_retry < 15) m_retry++;
      if (nxt != m_stage) begin
        m_t = 0; m_q = 0;
      end else begin
        m_t = (m_stage == S_PMA && !s_pll) ? 0 : m_t + 1;
        m_q = (m_stage == S_CDR && qual) ? m_q + 1 : 0;
      end
      m_stage = nxt;
    end
  end

  // Every-cycle comparison against the model and the disabled instance.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("model", dut_out(), model_out());
      chk("disabled", off_out(), 8'hC0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_v = 4'd0;
    @(negedge clk);
    chk("reset_state", dut_out(), 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] in;
    int         n;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [12];

  initial begin
    // Nominal bring-up, then LOS in DONE, then PLL loss.
    tbl[0]  = '{4'b1011, 5,  8'hC0};
    tbl[1]  = '{4'b1011, 1,  8'h40};
    tbl[2]  = '{4'b1011, 11, 8'h40};
    tbl[3]  = '{4'b1011, 1,  8'h00};
    tbl[4]  = '{4'b1011, 1,  8'h20};
    tbl[5]  = '{4'b1011, 1,  8'h20};
    tbl[6]  = '{4'b1011, 1,  8'h10};
    tbl[7]  = '{4'b1011, 5,  8'h10};
    tbl[8]  = '{4'b1111, 2,  8'h10};
    tbl[9]  = '{4'b1111, 1,  8'h40};
    tbl[10] = '{4'b0111, 2,  8'h40};
    tbl[11] = '{4'b0111, 1,  8'hC0};

    rst_n  = 1'b1;
    in_v   = 4'd0;
    chk_on = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_v = tbl[i].in;
      tick(tbl[i].n);
      chk($sformatf("table_%0d", i), dut_out(), tbl[i].exp);
    end

    // CDR glitch at qcnt=5 restarts qualification.
    do_reset();
    in_v = 4'b1011;
    tick(9);  in_v = 4'b1001;
    tick(1);  in_v = 4'b1011;
    tick(13); chk("glitch_pcs_held", dut_out(), 8'h40);
    tick(1);  chk("glitch_pcs_drop", dut_out(), 8'h00);

    // Word-align timeout retries and saturation.
    do_reset();
    in_v = 4'b1010;
    tick(37);  chk("timeout_pre", dut_out(), 8'h00);
    tick(1);   chk("timeout_1", dut_out(), 8'h41);
    tick(24);  chk("timeout_2", dut_out(), 8'h42);
    tick(311); chk("timeout_14", dut_out(), 8'h0E);
    tick(1);   chk("timeout_15", dut_out(), 8'h4F);
    tick(48);  chk("timeout_sat", dut_out(), 8'h4F);

    // Simultaneous loss events in DONE: PLL loss wins.
    do_reset();
    in_v = 4'b1011;
    tick(25); chk("simul_done", dut_out(), 8'h10);
    in_v = 4'b0110;
    tick(2);  chk("simul_hold", dut_out(), 8'h10);
    tick(1);  chk("simul_pma", dut_out(), 8'hC0);

    // Asynchronous reset during the FIFO clear pulse.
    do_reset();
    in_v = 4'b1011;
    tick(19); chk("clr_active", dut_out(), 8'h20);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_out(), 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);  chk("restart_pma_held", dut_out(), 8'hC0);
    tick(1);  chk("restart_pma_drop", dut_out(), 8'h40);

    // Randomised lane conditions checked against the model.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
        int mode;
        logic pll, los, cdr, wa;
        mode = (cyc / 150 + blk) % 3;
        pll  = ($urandom_range(0, 299) != 0);
        los  = ($urandom_range(0, 199) == 0);
        cdr  = (mode == 2) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 59) != 0);
        wa   = (mode == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) != 0);
        in_v = {pll, los, cdr, wa};
        tick(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
